// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the serial-to-parallel byte deserializer.
//   state_t : FSM states of the deserializer (IDLE, RECV, FULL)
//   NBITS   : number of serial bits assembled into one output word
//   CNT_W   : width of the received-bit counter (holds 0..NBITS)
// -----------------------------------------------------------------------------
package deser_pkg;

  localparam int NBITS = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } state_t;

endpackage

// File: rtl/shift_reg_8b_rtl.sv
// -----------------------------------------------------------------------------
// shift_reg_8b_rtl
// 8-bit assembly register with a synchronous clear and a single-bit indexed
// write port. When clr and we are both high the register is cleared and the
// indexed bit is written in the same edge, which is how a new frame starts.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset, clears q
//   clr  in   clear all bits to 0 at the next edge
//   we   in   write din into q[idx] at the next edge
//   idx  in   [2:0] physical bit index to write
//   din  in   data bit to write
//   q    out  [7:0] register contents
// -----------------------------------------------------------------------------
module shift_reg_8b_rtl (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [2:0] idx,
  input  logic       din,
  output logic [7:0] q
);

  logic [7:0] q_next;

  // Clear takes effect first so a frame-start write lands in an empty byte.
  always_comb begin
    q_next = clr ? 8'h00 : q;
    if (we) begin
      q_next[idx] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 8'h00;
    end else if (clr || we) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/deserializer_8b_rtl.sv
// -----------------------------------------------------------------------------
// deserializer_8b_rtl
// Serial-to-parallel front end: accepts one bit per cycle over a val/rdy
// handshake, assembles 8 bits into a byte and offers it on a val/rdy output.
// out_en pulses when the byte is consumed so a downstream 8-bit register can
// capture out_d in that same cycle. in_sof (with in_val) restarts a frame.
// Parameters:
//   MSB_FIRST  1: first accepted bit lands in out_d[7]; 0: in out_d[0]
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   in_val   in   serial bit valid
//   in_bit   in   serial data bit
//   in_sof   in   start-of-frame, qualified by in_val
//   in_rdy   out  block can accept a bit this cycle
//   out_val  out  assembled byte available
//   out_rdy  in   consumer accepts byte this cycle
//   out_d    out  [7:0] assembled byte (0 unless a full byte is held)
//   out_en   out  downstream load enable, out_val && out_rdy
// -----------------------------------------------------------------------------
module deserializer_8b_rtl
  import deser_pkg::*;
#(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_val,
  input  logic       in_bit,
  input  logic       in_sof,
  output logic       in_rdy,
  output logic       out_val,
  input  logic       out_rdy,
  output logic [7:0] out_d,
  output logic       out_en
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             xfer;
  logic             sr_clr;
  logic             sr_we;
  logic [2:0]       pos;
  logic [2:0]       idx;
  logic [7:0]       sr_q;

  assign in_rdy  = (state != FULL);
  assign out_val = (state == FULL);
  assign xfer    = in_val && in_rdy;
  assign out_en  = out_val && out_rdy;

  // The assembly register holds partial bits while receiving; only a
  // completed byte is ever shown downstream.
  assign out_d = out_val ? sr_q : 8'h00;

  // Frame position to physical bit index.
  assign idx = (MSB_FIRST != 0) ? (3'd7 - pos) : pos;

  // Write-port control: a frame start (first bit or resync) clears the byte
  // and writes position 0; any other accepted bit writes position count.
  always_comb begin
    sr_clr = 1'b0;
    sr_we  = 1'b0;
    pos    = 3'd0;
    case (state)
      IDLE: begin
        if (xfer) begin
          sr_clr = 1'b1;
          sr_we  = 1'b1;
        end
      end
      RECV: begin
        if (xfer) begin
          sr_we = 1'b1;
          if (in_sof) begin
            sr_clr = 1'b1;
          end else begin
            pos = count[2:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state <= RECV;
            count <= CNT_W'(1);
          end
        end
        RECV: begin
          if (xfer) begin
            if (in_sof) begin
              count <= CNT_W'(1);
            end else begin
              count <= count + CNT_W'(1);
              if (count == CNT_W'(NBITS - 1)) begin
                state <= FULL;
              end
            end
          end
        end
        FULL: begin
          if (out_rdy) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  shift_reg_8b_rtl u_shift (
    .clk (clk),
    .rst (rst),
    .clr (sr_clr),
    .we  (sr_we),
    .idx (idx),
    .din (in_bit),
    .q   (sr_q)
  );

endmodule

// File: tb/tb_deserializer_8b_rtl.sv
// -----------------------------------------------------------------------------
// tb_deserializer_8b_rtl
// Directed bench for deserializer_8b_rtl. Two instances share the same
// inputs: dut_m with MSB_FIRST=1 and dut_l with MSB_FIRST=0.
// -----------------------------------------------------------------------------
module tb_deserializer_8b_rtl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_val;
  logic       in_bit;
  logic       in_sof;
  logic       out_rdy;

  logic       m_in_rdy, m_out_val, m_out_en;
  logic [7:0] m_out_d;
  logic       l_in_rdy, l_out_val, l_out_en;
  logic [7:0] l_out_d;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  deserializer_8b_rtl #(.MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .in_val(in_val), .in_bit(in_bit), .in_sof(in_sof),
    .in_rdy(m_in_rdy), .out_val(m_out_val), .out_rdy(out_rdy),
    .out_d(m_out_d), .out_en(m_out_en)
  );

  deserializer_8b_rtl #(.MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .in_val(in_val), .in_bit(in_bit), .in_sof(in_sof),
    .in_rdy(l_in_rdy), .out_val(l_out_val), .out_rdy(out_rdy),
    .out_d(l_out_d), .out_en(l_out_en)
  );

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic sof);
    in_val = 1'b1;
    in_bit = b;
    in_sof = sof;
    tick();
    in_val = 1'b0;
    in_bit = 1'b0;
    in_sof = 1'b0;
  endtask

  // Sends the first n bits of seq in arrival order seq[7], seq[6], ...
  task automatic send_seq(input logic [7:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(seq[7-i], 1'b0);
    end
  endtask

  task automatic consume();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_val = 1'b0; in_bit = 1'b0; in_sof = 1'b0; out_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (m_in_rdy !== 1'b1) $display("[TB] FAIL reset_in_rdy: got %b expected 1", m_in_rdy); else passed++;
    checks++; if (m_out_val !== 1'b0) $display("[TB] FAIL reset_out_val: got %b expected 0", m_out_val); else passed++;
    checks++; if (m_out_d !== 8'h00) $display("[TB] FAIL reset_out_d: got %h expected 00", m_out_d); else passed++;
    checks++; if (m_out_en !== 1'b0) $display("[TB] FAIL reset_out_en: got %b expected 0", m_out_en); else passed++;
    checks++; if (l_out_val !== 1'b0) $display("[TB] FAIL reset_l_out_val: got %b expected 0", l_out_val); else passed++;
  endtask

  task automatic test_basic_byte();
    out_rdy = 1'b0;
    send_seq(8'hA5, 7);
    checks++; if (m_out_val !== 1'b0) $display("[TB] FAIL basic_partial_val: got %b expected 0", m_out_val); else passed++;
    checks++; if (m_out_d !== 8'h00) $display("[TB] FAIL basic_partial_d: got %h expected 00", m_out_d); else passed++;
    send_bit(1'b1, 1'b0);
    checks++; if (m_out_val !== 1'b1) $display("[TB] FAIL basic_out_val: got %b expected 1", m_out_val); else passed++;
    checks++; if (m_out_d !== 8'hA5) $display("[TB] FAIL basic_out_d: got %h expected a5", m_out_d); else passed++;
    checks++; if (m_in_rdy !== 1'b0) $display("[TB] FAIL basic_in_rdy: got %b expected 0", m_in_rdy); else passed++;
    checks++; if (l_out_d !== 8'hA5) $display("[TB] FAIL basic_l_out_d: got %h expected a5", l_out_d); else passed++;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (m_out_d !== 8'hA5 || m_out_val !== 1'b1) $display("[TB] FAIL basic_hold: got val=%b d=%h expected val=1 d=a5", m_out_val, m_out_d); else passed++;
    out_rdy = 1'b1;
    #1;
    checks++; if (m_out_en !== 1'b1) $display("[TB] FAIL basic_out_en: got %b expected 1", m_out_en); else passed++;
    tick();
    out_rdy = 1'b0;
    checks++; if (m_out_val !== 1'b0) $display("[TB] FAIL basic_after_val: got %b expected 0", m_out_val); else passed++;
    checks++; if (m_out_d !== 8'h00) $display("[TB] FAIL basic_after_d: got %h expected 00", m_out_d); else passed++;
    checks++; if (m_in_rdy !== 1'b1) $display("[TB] FAIL basic_after_in_rdy: got %b expected 1", m_in_rdy); else passed++;
    checks++; if (m_out_en !== 1'b0) $display("[TB] FAIL basic_after_en: got %b expected 0", m_out_en); else passed++;
  endtask

  // 8'h3C LSB first arrives as 0,0,1,1,1,1,0,0; a 2-cycle gap after 4 bits.
  task automatic test_gaps_lsb();
    send_seq(8'h3C, 4);
    tick();
    tick();
    checks++; if (l_out_val !== 1'b0) $display("[TB] FAIL gaps_mid_val: got %b expected 0", l_out_val); else passed++;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    checks++; if (l_out_val !== 1'b0) $display("[TB] FAIL gaps_7bit_val: got %b expected 0", l_out_val); else passed++;
    send_bit(1'b0, 1'b0);
    checks++; if (l_out_val !== 1'b1) $display("[TB] FAIL gaps_out_val: got %b expected 1", l_out_val); else passed++;
    checks++; if (l_out_d !== 8'h3C) $display("[TB] FAIL gaps_out_d: got %h expected 3c", l_out_d); else passed++;
    consume();
  endtask

  // Arrival order 0,0,0,1,0,0,1,0: MSB-first gives 12, LSB-first gives 48.
  task automatic test_bit_order();
    send_seq(8'h12, 8);
    checks++; if (m_out_d !== 8'h12) $display("[TB] FAIL order_msb: got %h expected 12", m_out_d); else passed++;
    checks++; if (l_out_d !== 8'h48) $display("[TB] FAIL order_lsb: got %h expected 48", l_out_d); else passed++;
    consume();
  endtask

  task automatic test_resync();
    send_seq(8'h00, 3);
    send_bit(1'b1, 1'b1);
    send_seq(8'hFF, 4);
    checks++; if (m_out_val !== 1'b0) $display("[TB] FAIL resync_early_val: got %b expected 0", m_out_val); else passed++;
    send_seq(8'hFF, 3);
    checks++; if (m_out_val !== 1'b1) $display("[TB] FAIL resync_out_val: got %b expected 1", m_out_val); else passed++;
    checks++; if (m_out_d !== 8'hFF) $display("[TB] FAIL resync_out_d: got %h expected ff", m_out_d); else passed++;
  endtask

  // Entered while still FULL with 8'hFF from the resync test.
  task automatic test_backpressure();
    out_rdy = 1'b0;
    in_val  = 1'b1;
    in_bit  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (m_in_rdy !== 1'b0) $display("[TB] FAIL bp_in_rdy: got %b expected 0", m_in_rdy); else passed++;
      checks++; if (m_out_d !== 8'hFF) $display("[TB] FAIL bp_out_d: got %h expected ff", m_out_d); else passed++;
    end
    in_val = 1'b0;
    consume();
    send_seq(8'h5A, 7);
    checks++; if (m_out_val !== 1'b0) $display("[TB] FAIL bp_next_7_val: got %b expected 0", m_out_val); else passed++;
    send_bit(1'b0, 1'b0);
    checks++; if (m_out_d !== 8'h5A) $display("[TB] FAIL bp_next_d: got %h expected 5a", m_out_d); else passed++;
    consume();
  endtask

  task automatic test_reset_mid();
    send_seq(8'hFF, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (m_in_rdy !== 1'b1 || m_out_val !== 1'b0) $display("[TB] FAIL rstmid_state: got rdy=%b val=%b expected rdy=1 val=0", m_in_rdy, m_out_val); else passed++;
    send_seq(8'h81, 7);
    checks++; if (m_out_val !== 1'b0) $display("[TB] FAIL rstmid_7_val: got %b expected 0", m_out_val); else passed++;
    send_bit(1'b1, 1'b0);
    checks++; if (m_out_d !== 8'h81) $display("[TB] FAIL rstmid_out_d: got %h expected 81", m_out_d); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_rdy = 1'b1;
    #1;
    checks++; if (m_out_val !== 1'b0) $display("[TB] FAIL rstfull_val: got %b expected 0", m_out_val); else passed++;
    checks++; if (m_out_en !== 1'b0) $display("[TB] FAIL rstfull_en: got %b expected 0", m_out_en); else passed++;
    checks++; if (m_out_d !== 8'h00) $display("[TB] FAIL rstfull_d: got %h expected 00", m_out_d); else passed++;
    tick();
    checks++; if (m_out_en !== 1'b0) $display("[TB] FAIL rstfull_en_later: got %b expected 0", m_out_en); else passed++;
    out_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_byte();
    test_gaps_lsb();
    test_bit_order();
    test_resync();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
